// File: rtl/nn_wb_regbank.sv
// nn_wb_regbank
//   Wishbone classic slave that sits between the management SoC and the NN
//   datapath core. It holds the operand and weight registers that feed the
//   core in parallel, sequences the core with a start/done handshake,
//   buffers results in a small FIFO, and drives the LED bank and an
//   interrupt line. A run is started by software (CTRL.start) or by a
//   rising edge on the synchronised user switch.
//
// Ports
//   clk, rst_l          clock, asynchronous active-low reset
//   wbs_*               Wishbone classic slave (byte offsets in adr[7:0])
//   sw_start_i          asynchronous user switch, hardware start source
//   core_in_o/core_w_o  packed operands/weights, element 0 in the LSBs
//   core_start_o        one-cycle start pulse to the core
//   core_done_i         result-valid pulse, core_result_i valid with it
//   led_o               registered LED drive, source chosen by CTRL.led_sel
//   irq_o               registered level interrupt
//
// Handshake: an access is taken when cyc & stb are high and no ack is
// outstanding; ack (with read data) follows one cycle later for exactly one
// cycle, so the master must drop or re-present stb after seeing ack.
//
// Register map (byte offsets)
//   0x00 CTRL     bit0 start (write-1 pulse), bit1 hw_start_en, bit2 irq_en,
//                 bits[4:3] led_sel
//   0x04 STATUS   bit0 busy, bit1 fifo_empty, bit2 fifo_full, bit3 timeout,
//                 bit4 underflow, bit5 wr_busy_err, bit6 bad_addr
//                 (bits 3-6 sticky, write-1-to-clear), bits[15:8] count
//   0x08 RESULT   read pops the FIFO head
//   0x0C LAST     most recent result pushed
//   0x10+4i       INPUT[i]
//   0x40+4j       WEIGHT[j]
module nn_wb_regbank #(
    parameter int N_IN        = 2,
    parameter int N_W         = 6,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic                sw_start_i,
    output logic [32*N_IN-1:0]  core_in_o,
    output logic [32*N_W-1:0]   core_w_o,
    output logic                core_start_o,
    input  logic                core_done_i,
    input  logic [31:0]         core_result_i,
    output logic [31:0]         led_o,
    output logic                irq_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_RESULT = 8'h08;
    localparam logic [7:0] OFF_LAST   = 8'h0C;
    localparam int         OFF_INPUT  = 16;
    localparam int         OFF_WEIGHT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                   pending_q, pending_d;
    logic                   ack_q, ack_d;
    logic [31:0]            dat_q, dat_d;
    logic [31:0]            led_q, led_d;
    logic                   irq_q, irq_d;
    logic                   hw_en_q, hw_en_d;
    logic                   irq_en_q, irq_en_d;
    logic [1:0]             led_sel_q, led_sel_d;
    logic [32*N_IN-1:0]     in_q, in_d;
    logic [32*N_W-1:0]      w_q, w_d;
    logic [31:0]            last_q, last_d;
    logic                   timeout_q, timeout_d;
    logic                   underflow_q, underflow_d;
    logic                   wr_busy_err_q, wr_busy_err_d;
    logic                   bad_addr_q, bad_addr_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sw_prev_q, sw_prev_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [31:0]            fifo_mem_q [FIFO_DEPTH];

    logic        valid;
    logic        wr_acc;
    logic        rd_acc;
    logic [7:0]  off;
    logic        in_hit;
    logic        w_hit;
    logic        mapped;
    logic [31:0] rd_data;
    logic [31:0] status_word;
    logic [31:0] ctrl_word;
    logic [31:0] fifo_head;
    logic        fifo_empty;
    logic        fifo_full;
    logic        busy;
    logic        locked;
    logic        sw_start_req;
    logic        hw_rise;
    logic        start_req;
    logic        push;
    logic        pop;
    logic        tmo_event;
    logic        unused_adr;

    // Only the low byte of the address is decoded.
    assign unused_adr = ^wbs_adr_i[31:8];

    assign valid  = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign wr_acc = valid & wbs_we_i;
    assign rd_acc = valid & ~wbs_we_i;
    assign off    = wbs_adr_i[7:0];

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_head  = fifo_mem_q[rd_ptr_q];

    // STATUS.busy reports RUN only; the operand registers stay locked through
    // START as well so the core never sees them change under its start pulse.
    assign busy   = (state_q == ST_RUN);
    assign locked = (state_q != ST_IDLE);

    assign status_word = {16'h0, 8'(count_q), 1'b0, bad_addr_q, wr_busy_err_q,
                          underflow_q, timeout_q, fifo_full, fifo_empty, busy};
    assign ctrl_word   = {27'h0, led_sel_q, irq_en_q, hw_en_q, 1'b0};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    // Address decode and read mux.
    always_comb begin
        in_hit  = 1'b0;
        w_hit   = 1'b0;
        rd_data = 32'h0;
        case (off)
            OFF_CTRL:   rd_data = ctrl_word;
            OFF_STATUS: rd_data = status_word;
            OFF_RESULT: rd_data = fifo_empty ? 32'h0 : fifo_head;
            OFF_LAST:   rd_data = last_q;
            default:    rd_data = 32'h0;
        endcase
        for (int i = 0; i < N_IN; i++) begin
            if (off == 8'(OFF_INPUT + 4 * i)) begin
                in_hit  = 1'b1;
                rd_data = in_q[32*i +: 32];
            end
        end
        for (int j = 0; j < N_W; j++) begin
            if (off == 8'(OFF_WEIGHT + 4 * j)) begin
                w_hit   = 1'b1;
                rd_data = w_q[32*j +: 32];
            end
        end
    end

    assign mapped = (off == OFF_CTRL) | (off == OFF_STATUS) | (off == OFF_RESULT) |
                    (off == OFF_LAST) | in_hit | w_hit;

    // Bus side: register writes, sticky flags, FIFO pop, read data.
    always_comb begin
        ack_d         = valid;
        dat_d         = rd_acc ? rd_data : 32'h0;
        hw_en_d       = hw_en_q;
        irq_en_d      = irq_en_q;
        led_sel_d     = led_sel_q;
        in_d          = in_q;
        w_d           = w_q;
        timeout_d     = timeout_q;
        underflow_d   = underflow_q;
        wr_busy_err_d = wr_busy_err_q;
        bad_addr_d    = bad_addr_q;
        sw_start_req  = 1'b0;
        pop           = 1'b0;

        if (wr_acc) begin
            if (off == OFF_CTRL && wbs_sel_i[0]) begin
                hw_en_d      = wbs_dat_i[1];
                irq_en_d     = wbs_dat_i[2];
                led_sel_d    = wbs_dat_i[4:3];
                sw_start_req = wbs_dat_i[0];
            end
            if (off == OFF_STATUS && wbs_sel_i[0]) begin
                if (wbs_dat_i[3]) timeout_d     = 1'b0;
                if (wbs_dat_i[4]) underflow_d   = 1'b0;
                if (wbs_dat_i[5]) wr_busy_err_d = 1'b0;
                if (wbs_dat_i[6]) bad_addr_d    = 1'b0;
            end
            for (int i = 0; i < N_IN; i++) begin
                if (off == 8'(OFF_INPUT + 4 * i)) begin
                    if (locked) wr_busy_err_d = 1'b1;
                    else in_d[32*i +: 32] = merge_bytes(in_q[32*i +: 32], wbs_dat_i, wbs_sel_i);
                end
            end
            for (int j = 0; j < N_W; j++) begin
                if (off == 8'(OFF_WEIGHT + 4 * j)) begin
                    if (locked) wr_busy_err_d = 1'b1;
                    else w_d[32*j +: 32] = merge_bytes(w_q[32*j +: 32], wbs_dat_i, wbs_sel_i);
                end
            end
        end

        if (rd_acc && off == OFF_RESULT) begin
            if (fifo_empty) underflow_d = 1'b1;
            else            pop         = 1'b1;
        end

        if (valid && !mapped) bad_addr_d = 1'b1;

        // A timeout landing on the same cycle as a clear must not be lost.
        if (tmo_event) timeout_d = 1'b1;
    end

    // Switch synchroniser and rising-edge detect.
    always_comb begin
        sync_d    = (sync_q << 1) | SYNC_STAGES'(sw_start_i);
        sw_prev_d = sync_q[SYNC_STAGES-1];
    end

    assign hw_rise   = sync_q[SYNC_STAGES-1] & ~sw_prev_q;
    assign start_req = sw_start_req | (hw_en_q & hw_rise);

    // Run sequencer. A start arriving while the FIFO is full is remembered
    // (one deep) and launched once a RESULT read frees an entry.
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        pending_d = pending_q;
        last_d    = last_q;
        push      = 1'b0;
        tmo_event = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((start_req || pending_q) && !fifo_full) begin
                    state_d   = ST_START;
                    pending_d = 1'b0;
                end else if (start_req) begin
                    pending_d = 1'b1;
                end
            end
            ST_START: begin
                tmo_cnt_d = '0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (core_done_i) begin
                    push    = 1'b1;
                    last_d  = core_result_i;
                    state_d = ST_IDLE;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    tmo_event = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign core_start_o = (state_q == ST_START);

    // FIFO pointers and occupancy.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // LED source select and interrupt.
    always_comb begin
        case (led_sel_q)
            2'd0:    led_d = last_q;
            2'd1:    led_d = fifo_empty ? 32'h0 : fifo_head;
            2'd2:    led_d = status_word;
            default: led_d = in_q[31:0];
        endcase
        irq_d = irq_en_q & (~fifo_empty | timeout_q | underflow_q | wr_busy_err_q | bad_addr_q);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q       <= ST_IDLE;
            tmo_cnt_q     <= '0;
            pending_q     <= 1'b0;
            ack_q         <= 1'b0;
            dat_q         <= '0;
            led_q         <= '0;
            irq_q         <= 1'b0;
            hw_en_q       <= 1'b0;
            irq_en_q      <= 1'b0;
            led_sel_q     <= '0;
            in_q          <= '0;
            w_q           <= '0;
            last_q        <= '0;
            timeout_q     <= 1'b0;
            underflow_q   <= 1'b0;
            wr_busy_err_q <= 1'b0;
            bad_addr_q    <= 1'b0;
            sync_q        <= '0;
            sw_prev_q     <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            tmo_cnt_q     <= tmo_cnt_d;
            pending_q     <= pending_d;
            ack_q         <= ack_d;
            dat_q         <= dat_d;
            led_q         <= led_d;
            irq_q         <= irq_d;
            hw_en_q       <= hw_en_d;
            irq_en_q      <= irq_en_d;
            led_sel_q     <= led_sel_d;
            in_q          <= in_d;
            w_q           <= w_d;
            last_q        <= last_d;
            timeout_q     <= timeout_d;
            underflow_q   <= underflow_d;
            wr_busy_err_q <= wr_busy_err_d;
            bad_addr_q    <= bad_addr_d;
            sync_q        <= sync_d;
            sw_prev_q     <= sw_prev_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
        end else if (push) begin
            fifo_mem_q[wr_ptr_q] <= core_result_i;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign core_in_o = in_q;
    assign core_w_o  = w_q;
    assign led_o     = led_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_nn_wb_regbank.sv
module tb_nn_wb_regbank;

  localparam int N_IN = 2;
  localparam int N_W = 6;
  localparam logic [7:0] A_CTRL = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_RESULT = 8'h08;
  localparam logic [7:0] A_LAST = 8'h0C;
  localparam logic [7:0] A_IN0 = 8'h10;
  localparam logic [7:0] A_IN1 = 8'h14;
  localparam logic [7:0] A_W0 = 8'h40;
  localparam logic [7:0] A_W5 = 8'h54;

  logic clk = 1'b0;
  logic rst_l;
  logic wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0] wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic sw_start_i;
  logic [32*N_IN-1:0] core_in_o;
  logic [32*N_W-1:0] core_w_o;
  logic core_start_o;
  logic core_done_i;
  logic [31:0] core_result_i;
  logic [31:0] led_o;
  logic irq_o;

  int checks = 0;
  int errors = 0;

  // core model controls (written by the stimulus block only)
  logic model_en = 1'b1;
  int model_delay = 5;
  logic [31:0] model_base = 32'h0;

  // model / monitor state (written by their own blocks only)
  int model_cd = 0;
  int start_cnt = 0;
  int busy_cnt = 0;

  nn_wb_regbank #(
    .N_IN(N_IN), .N_W(N_W), .FIFO_DEPTH(4), .TIMEOUT_CYC(1024), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_l(rst_l),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .sw_start_i(sw_start_i),
    .core_in_o(core_in_o), .core_w_o(core_w_o),
    .core_start_o(core_start_o), .core_done_i(core_done_i),
    .core_result_i(core_result_i),
    .led_o(led_o), .irq_o(irq_o)
  );

  // clock
  always #5 clk = ~clk;

  // core model: done pulse model_delay cycles after the start pulse
  always @(negedge clk) begin
    core_done_i = 1'b0;
    if (model_cd > 0) begin
      model_cd = model_cd - 1;
      if (model_cd == 0) begin
        core_done_i = 1'b1;
        core_result_i = model_base;
      end
    end
    if (core_start_o && model_en) model_cd = model_delay;
  end

  // monitor: start pulses and busy cycles (busy seen on led_o[0] with led_sel=2)
  always @(negedge clk) begin
    if (core_start_o) start_cnt++;
    if (led_o[0]) busy_cnt++;
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_access(input logic we, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] sel, output logic [31:0] rdata);
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = {24'h300000, a}; wbs_dat_i = d; wbs_sel_i = sel;
    @(negedge clk);
    check32("ack_early", 32'(wbs_ack_o), 32'h0);
    @(negedge clk);
    check32("ack", 32'(wbs_ack_o), 32'h1);
    rdata = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(negedge clk);
    check32("ack_one_cycle", 32'(wbs_ack_o), 32'h0);
    check32("dat_idle", wbs_dat_o, 32'h0);
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] dummy;
    wb_access(1'b1, a, d, sel, dummy);
  endtask

  task automatic wb_read(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] r;
    wb_access(1'b0, a, 32'h0, 4'hF, r);
    check32(tag, r, exp);
  endtask

  initial begin
    int s0, b0;
    rst_l = 1'b0;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    sw_start_i = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_ack", 32'(wbs_ack_o), 32'h0);
    check32("rst_dat", wbs_dat_o, 32'h0);
    check32("rst_start", 32'(core_start_o), 32'h0);
    check32("rst_led", led_o, 32'h0);
    check32("rst_irq", 32'(irq_o), 32'h0);
    check32("rst_in0", core_in_o[31:0], 32'h0);
    @(posedge clk); #1 rst_l = 1'b1;
    wb_read("rst_status", A_STATUS, 32'h0000_0002);

    // operand write / read-back
    wb_write(A_IN0, 32'h3F80_0000, 4'hF);
    wb_write(A_IN1, 32'h4000_0000, 4'hF);
    wb_read("in0_rb", A_IN0, 32'h3F80_0000);
    wb_read("in1_rb", A_IN1, 32'h4000_0000);
    check32("core_in_lo", core_in_o[31:0], 32'h3F80_0000);
    check32("core_in_hi", core_in_o[63:32], 32'h4000_0000);

    // single software run, led_sel=2 shows STATUS
    model_base = 32'h3F00_0000; model_delay = 5;
    s0 = start_cnt; b0 = busy_cnt;
    wb_write(A_CTRL, 32'h11, 4'hF);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check32("sw_start_pulses", 32'(start_cnt - s0), 32'd1);
    check32("sw_busy_cycles", 32'(busy_cnt - b0), 32'd5);
    wb_read("status_one", A_STATUS, 32'h0000_0100);
    wb_read("result_one", A_RESULT, 32'h3F00_0000);
    wb_read("status_drained", A_STATUS, 32'h0000_0002);
    wb_read("last_one", A_LAST, 32'h3F00_0000);
    check32("led_status", led_o, 32'h0000_0002);

    // fill the FIFO, then one start held pending
    s0 = start_cnt;
    for (int k = 0; k < 4; k++) begin
      model_base = 32'h1000 + 32'(k);
      wb_write(A_CTRL, 32'h11, 4'hF);
      repeat (10) @(posedge clk);
    end
    wb_read("status_full", A_STATUS, 32'h0000_0404);
    model_base = 32'h1004;
    wb_write(A_CTRL, 32'h11, 4'hF);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check32("pending_held", 32'(start_cnt - s0), 32'd4);
    wb_read("result_first", A_RESULT, 32'h1000);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check32("pending_released", 32'(start_cnt - s0), 32'd5);
    wb_read("status_refull", A_STATUS, 32'h0000_0404);
    wb_read("last_pending", A_LAST, 32'h1004);
    for (int k = 1; k < 5; k++) wb_read("result_drain", A_RESULT, 32'h1000 + 32'(k));

    // RESULT read while empty
    wb_read("result_empty", A_RESULT, 32'h0);
    wb_read("status_underflow", A_STATUS, 32'h0000_0012);
    wb_write(A_STATUS, 32'h10, 4'hF);
    wb_read("status_unf_clr", A_STATUS, 32'h0000_0002);

    // timeout with irq enabled
    model_en = 1'b0;
    s0 = start_cnt; b0 = busy_cnt;
    wb_write(A_CTRL, 32'h15, 4'hF);
    check32("irq_quiet", 32'(irq_o), 32'h0);
    repeat (1030) @(posedge clk);
    @(negedge clk);
    check32("tmo_start_pulses", 32'(start_cnt - s0), 32'd1);
    check32("tmo_busy_cycles", 32'(busy_cnt - b0), 32'd1024);
    check32("tmo_irq", 32'(irq_o), 32'h1);
    wb_read("status_timeout", A_STATUS, 32'h0000_000A);
    wb_write(A_STATUS, 32'h08, 4'hF);
    check32("tmo_irq_clr", 32'(irq_o), 32'h0);
    wb_read("status_tmo_clr", A_STATUS, 32'h0000_0002);
    model_en = 1'b1;

    // hardware start from the switch
    model_base = 32'h2000; model_delay = 5;
    wb_write(A_CTRL, 32'h12, 4'hF);
    s0 = start_cnt;
    @(posedge clk); #3 sw_start_i = 1'b1;
    @(negedge clk); check32("hw_lat0", 32'(core_start_o), 32'h0);
    @(negedge clk); check32("hw_lat1", 32'(core_start_o), 32'h0);
    @(negedge clk); check32("hw_lat2", 32'(core_start_o), 32'h0);
    @(negedge clk); check32("hw_pulse", 32'(core_start_o), 32'h1);
    @(negedge clk); check32("hw_pulse_end", 32'(core_start_o), 32'h0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check32("hw_single_start", 32'(start_cnt - s0), 32'd1);
    #2 sw_start_i = 1'b0;
    wb_read("hw_result", A_RESULT, 32'h2000);

    // byte selects on WEIGHT[5]
    wb_write(A_W5, 32'hAABB_CCDD, 4'hF);
    wb_write(A_W5, 32'h1122_3344, 4'b0101);
    check32("w5_bytes", core_w_o[191:160], 32'hAA22_CC44);
    wb_read("w5_rb", A_W5, 32'hAA22_CC44);

    // WEIGHT[0] write during RUN is discarded
    wb_write(A_W0, 32'h1111_1111, 4'hF);
    model_base = 32'h3000; model_delay = 20;
    wb_write(A_CTRL, 32'h11, 4'hF);
    wb_write(A_W0, 32'hDEAD_BEEF, 4'hF);
    check32("w0_locked", core_w_o[31:0], 32'h1111_1111);
    repeat (30) @(posedge clk);
    wb_read("w0_rb", A_W0, 32'h1111_1111);
    wb_read("status_wbe", A_STATUS, 32'h0000_0120);

    // LED sources
    wb_write(A_CTRL, 32'h08, 4'hF);
    check32("led_head", led_o, 32'h3000);
    wb_write(A_CTRL, 32'h18, 4'hF);
    check32("led_in0", led_o, 32'h3F80_0000);
    wb_write(A_CTRL, 32'h00, 4'hF);
    check32("led_last", led_o, 32'h3000);
    wb_read("result_run", A_RESULT, 32'h3000);
    wb_write(A_STATUS, 32'h20, 4'hF);

    // unmapped offset
    wb_write(8'hFC, 32'h1234_5678, 4'hF);
    wb_read("unmapped_rd", 8'hFC, 32'h0);
    wb_read("status_bad", A_STATUS, 32'h0000_0042);
    wb_write(A_STATUS, 32'h40, 4'hF);
    wb_read("status_bad_clr", A_STATUS, 32'h0000_0002);

    // reset during RUN: late done must not be captured
    model_base = 32'h5000; model_delay = 20;
    wb_write(A_CTRL, 32'h01, 4'hF);
    repeat (3) @(posedge clk);
    #1 rst_l = 1'b0;
    @(negedge clk);
    check32("midrst_in0", core_in_o[31:0], 32'h0);
    check32("midrst_start", 32'(core_start_o), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b1;
    repeat (30) @(posedge clk);
    wb_read("midrst_status", A_STATUS, 32'h0000_0002);
    wb_read("midrst_last", A_LAST, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
